// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C master arbiter slice.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} arb_state_t;
endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping around.
module i2c_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any
);
  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate back to last+1 so the nearest one is written last and wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin front end sharing one byte-level I2C master between NREQ requesters,
// with a grant-to-done watchdog and drain of a hung master before reuse.
module i2c_master_arbiter import i2c_pkg::*; #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]            req_op,
  input  logic [NREQ*I2C_DATA_W-1:0] req_din,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [I2C_DATA_W-1:0]      rsp_data,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  output logic                       m_newd,
  output logic [I2C_ADDR_W-1:0]      m_addr,
  output logic                       m_op,
  output logic [I2C_DATA_W-1:0]      m_din,
  input  logic                       m_busy,
  input  logic                       m_done,
  input  logic                       m_ack_err,
  input  logic [I2C_DATA_W-1:0]      m_dout
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t state, state_nxt;

  logic [NREQ-1:0][I2C_ADDR_W-1:0] addr_a;
  logic [NREQ-1:0][I2C_DATA_W-1:0] din_a;
  logic [IDX_W-1:0] cur, rr_last, pick;
  logic             pick_any, grant, in_xfer, wd_exp;
  logic [WD_W-1:0]  wdog;

  assign addr_a  = req_addr;
  assign din_a   = req_din;
  assign grant   = (state == IDLE) && pick_any && !m_busy;
  assign in_xfer = (state == ISSUE) || (state == WAIT);
  assign wd_exp  = (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  i2c_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .last  (rr_last),
    .winner(pick),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (wd_exp) state_nxt = RESP;
               else if (m_busy) state_nxt = WAIT;
      // A done pulse coinciding with expiry is a normal completion.
      WAIT:    if (m_done || wd_exp) state_nxt = RESP;
      RESP:    state_nxt = rsp_timeout ? DRAIN : IDLE;
      DRAIN:   if (!m_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    m_newd    = 1'b0;
    case (state)
      ISSUE: begin
        gnt[cur] = 1'b1;
        m_newd   = 1'b1;
      end
      WAIT:  gnt[cur] = 1'b1;
      RESP: begin
        gnt[cur]       = 1'b1;
        rsp_valid[cur] = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are latched only at grant so requesters may change them mid-flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur         <= '0;
      rr_last     <= IDX_W'(NREQ - 1);
      m_addr      <= '0;
      m_op        <= 1'b0;
      m_din       <= '0;
      wdog        <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (grant) begin
        cur     <= pick;
        rr_last <= pick;
        m_addr  <= addr_a[pick];
        m_op    <= req_op[pick];
        m_din   <= din_a[pick];
        wdog    <= '0;
      end else if (in_xfer) begin
        wdog <= wdog + WD_W'(1);
      end
      if (state == WAIT && m_done) begin
        rsp_data    <= m_op ? m_dout : '0;
        rsp_err     <= m_ack_err;
        rsp_timeout <= 1'b0;
      end else if (in_xfer && wd_exp) begin
        rsp_data    <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule
